// File: rtl/out_fm_ld_rd_ctrl_pkg.sv
// Shared definitions for the out_fm load read controller: FSM state encodings and
// the width derivation for per-tile word counts.
package out_fm_ld_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Bits needed to hold any count in 0..total inclusive.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total == 0) ? 1 : $clog2(total + 1);
  endfunction

endpackage

// File: rtl/nest3_counter.sv
// Three nested wrap-around counters; n0 runs fastest, n2 slowest. All advance only on i_ena.
module nest3_counter #(
  parameter int unsigned CW     = 16,
  parameter int unsigned N0_MAX = 18,
  parameter int unsigned N1_MAX = 64,
  parameter int unsigned N2_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_ena,
  output logic [CW-1:0] o_n0,
  output logic [CW-1:0] o_n1,
  output logic [CW-1:0] o_n2,
  output logic          o_last
);

  logic [CW-1:0] r_n0, r_n1, r_n2;
  logic          w_n0_top, w_n1_top, w_n2_top;

  assign w_n0_top = (r_n0 == CW'(N0_MAX - 1));
  assign w_n1_top = (r_n1 == CW'(N1_MAX - 1));
  assign w_n2_top = (r_n2 == CW'(N2_MAX - 1));

  // High while the counters sit on the final point of the full nest.
  assign o_last = w_n0_top && w_n1_top && w_n2_top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n0 <= '0;
      r_n1 <= '0;
      r_n2 <= '0;
    end else if (i_clr) begin
      r_n0 <= '0;
      r_n1 <= '0;
      r_n2 <= '0;
    end else if (i_ena) begin
      if (!w_n0_top) begin
        r_n0 <= r_n0 + CW'(1);
      end else begin
        r_n0 <= '0;
        if (!w_n1_top) begin
          r_n1 <= r_n1 + CW'(1);
        end else begin
          r_n1 <= '0;
          r_n2 <= w_n2_top ? '0 : r_n2 + CW'(1);
        end
      end
    end
  end

  assign o_n0 = r_n0;
  assign o_n1 = r_n1;
  assign o_n2 = r_n2;

endmodule

// File: rtl/out_fm_ld_rd_ctrl.sv
// Issues one tile of out_fm word reads to memory with bounded outstanding requests and
// forwards the in-order returns to the downstream ld filter one cycle later.
module out_fm_ld_rd_ctrl
  import out_fm_ld_rd_ctrl_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned CW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned N           = 32,
  parameter int unsigned R           = 64,
  parameter int unsigned C           = 32,
  parameter int unsigned Tn          = 16,
  parameter int unsigned Tr          = 64,
  parameter int unsigned Tc          = 16,
  parameter int unsigned tile_offset = 2,
  parameter int unsigned MAX_OUT     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] tile_base_n,
  input  logic [CW-1:0] tile_base_row,
  input  logic [CW-1:0] tile_base_col,
  input  logic          fifo_almost_full,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_rd_addr,
  input  logic          mem_rd_ready,
  input  logic          mem_rd_data_valid,
  input  logic [DW-1:0] mem_rd_data,
  output logic          fifo_push_tmp,
  output logic [DW-1:0] data_to_fifo_tmp,
  output logic          busy,
  output logic          done
);

  localparam int unsigned NCol  = Tc + tile_offset;
  localparam int unsigned Total = Tn * Tr * NCol;
  localparam int unsigned TW    = cnt_width(Total);
  localparam int unsigned OW    = cnt_width(MAX_OUT);
  localparam int unsigned PW    = 2 * CW;

  state_e        r_state, w_state_d;
  logic [CW-1:0] r_base_n, r_base_row, r_base_col;
  logic [OW-1:0] r_out;
  logic [TW-1:0] r_ret_cnt;
  logic          r_push;
  logic [DW-1:0] r_push_data;

  logic          w_start_acc, w_req, w_accept, w_ret, w_last;
  logic [CW-1:0] w_tc, w_tr, w_tn;
  logic [PW-1:0] w_n_sum, w_row_sum;

  nest3_counter #(
    .CW    (CW),
    .N0_MAX(NCol),
    .N1_MAX(Tr),
    .N2_MAX(Tn)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start_acc),
    .i_ena (w_accept),
    .o_n0  (w_tc),
    .o_n1  (w_tr),
    .o_n2  (w_tn),
    .o_last(w_last)
  );

  always_comb begin
    w_state_d   = r_state;
    w_start_acc = 1'b0;
    w_req       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_d   = StIssue;
        end
      end
      StIssue: begin
        w_req = (r_out < OW'(MAX_OUT)) && !fifo_almost_full;
        if (w_req && mem_rd_ready && w_last) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if ((r_ret_cnt == TW'(Total)) && (r_out == '0)) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept = w_req && mem_rd_ready;
  // Returns with nothing outstanding (e.g. after an abandoned tile) are not counted.
  assign w_ret    = mem_rd_data_valid && (r_out != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_base_n   <= '0;
      r_base_row <= '0;
      r_base_col <= '0;
      r_out      <= '0;
      r_ret_cnt  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start_acc) begin
        r_base_n   <= tile_base_n;
        r_base_row <= tile_base_row;
        r_base_col <= tile_base_col;
      end
      if (w_accept && !w_ret) begin
        r_out <= r_out + OW'(1);
      end else if (!w_accept && w_ret) begin
        r_out <= r_out - OW'(1);
      end
      if (w_start_acc) begin
        r_ret_cnt <= '0;
      end else if (w_ret && ((r_state == StIssue) || (r_state == StDrain))) begin
        r_ret_cnt <= r_ret_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push      <= mem_rd_data_valid;
      r_push_data <= mem_rd_data;
    end
  end

  // Products formed at 2*CW bits, then truncated to the memory address width.
  assign w_n_sum   = PW'(r_base_n) + PW'(w_tn);
  assign w_row_sum = PW'(r_base_row) + PW'(w_tr);
  assign mem_rd_addr = AW'((w_n_sum * PW'(R) + w_row_sum) * PW'(C) + PW'(r_base_col) + PW'(w_tc));

  assign mem_rd_req       = w_req;
  assign fifo_push_tmp    = r_push;
  assign data_to_fifo_tmp = r_push_data;
  assign busy             = (r_state != StIdle);
  assign done             = (r_state == StDone);

endmodule

// File: tb/tb_out_fm_ld_rd_ctrl.sv
// Directed bench for out_fm_ld_rd_ctrl with a small tile, a latency-2 memory model and a
// push scoreboard.
module tb_out_fm_ld_rd_ctrl;

  localparam int unsigned NumRd = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] tile_base_n, tile_base_row, tile_base_col;
  logic        fifo_almost_full;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic        mem_rd_data_valid;
  logic [31:0] mem_rd_data;
  logic        fifo_push_tmp;
  logic [31:0] data_to_fifo_tmp;
  logic        busy;
  logic        done;

  out_fm_ld_rd_ctrl #(
    .AW(16), .CW(16), .DW(32), .N(4), .R(4), .C(6), .Tn(2), .Tr(2), .Tc(4),
    .tile_offset(2), .MAX_OUT(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .tile_base_n      (tile_base_n),
    .tile_base_row    (tile_base_row),
    .tile_base_col    (tile_base_col),
    .fifo_almost_full (fifo_almost_full),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_data_valid(mem_rd_data_valid),
    .mem_rd_data      (mem_rd_data),
    .fifo_push_tmp    (fifo_push_tmp),
    .data_to_fifo_tmp (data_to_fifo_tmp),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic [15:0] addr; int due;} rd_t;
  rd_t         mem_q[$];
  logic [15:0] acc_addr[$];

  int          cyc = 0;
  int          b_out = 0, b_acc = 0, b_tc = 0, b_tr = 0, b_tn = 0;
  bit          b_issuing = 0;
  bit          mem_en = 1, rdy_rand = 0;
  bit          prev_valid = 0;
  logic [31:0] prev_data = '0;
  int          push_cnt = 0, last_push_cyc = 0, done_cyc = 0, done_cnt = 0;
  int          first_acc_cyc = 0, last_acc_cyc = 0;

  function automatic logic [15:0] exp_addr(input int tn, input int tr, input int tc);
    int a;
    a = ((int'(tile_base_n) + tn) * 4 + (int'(tile_base_row) + tr)) * 6 + int'(tile_base_col) + tc;
    return a[15:0];
  endfunction

  // Memory model, reference counters and output scoreboard, all on the falling edge.
  always @(negedge clk) begin
    bit acc, vld;
    cyc++;
    if (rst) begin
      mem_q.delete();
      mem_rd_data_valid = 1'b0;
      mem_rd_ready      = 1'b1;
      prev_valid        = 0;
      b_out             = 0;
      b_issuing         = 0;
    end else begin
      chk("push", fifo_push_tmp, prev_valid);
      if (prev_valid) begin
        chk("push_data", data_to_fifo_tmp, prev_data);
        push_cnt++;
        last_push_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (b_issuing) chk("addr", mem_rd_addr, exp_addr(b_tn, b_tr, b_tc));
      chk("req", mem_rd_req, b_issuing && (b_out < 4) && !fifo_almost_full);
      mem_rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = mem_rd_req && mem_rd_ready;
      vld = 0;
      if (mem_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
        vld = 1;
        mem_rd_data = 32'hC0DE_0000 | 32'(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
      mem_rd_data_valid = vld;
      prev_valid = vld;
      prev_data  = mem_rd_data;
      if (acc) begin
        mem_q.push_back('{addr: mem_rd_addr, due: cyc + 2});
        acc_addr.push_back(mem_rd_addr);
        if (b_acc == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        b_acc++;
        b_tc++;
        if (b_tc == 6) begin
          b_tc = 0;
          b_tr++;
          if (b_tr == 2) begin
            b_tr = 0;
            b_tn++;
            if (b_tn == 2) b_tn = 0;
          end
        end
        if (b_acc == NumRd) b_issuing = 0;
      end
      b_out = b_out + int'(acc) - int'(vld);
      if (start && !b_issuing) begin
        b_issuing = 1;
        b_acc = 0; b_tc = 0; b_tr = 0; b_tn = 0;
        push_cnt = 0; done_cnt = 0;
        acc_addr.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_tile(input logic [15:0] bn, input logic [15:0] br, input logic [15:0] bc);
    tick();
    tile_base_n   = bn;
    tile_base_row = br;
    tile_base_col = bc;
    pulse_start();
  endtask

  task automatic wait_acc(input int n);
    int i;
    for (i = 0; i < 300; i++) begin
      if (b_acc >= n) break;
      tick();
    end
    if (i == 300) chk("acc_timeout", 32'(b_acc), 32'(n));
  endtask

  task automatic finish_tile(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
    if (i == 400) chk({tag, "_done_timeout"}, 0, 1);
    repeat (3) tick();
    chk({tag, "_accepts"}, 32'(b_acc), NumRd);
    chk({tag, "_pushes"}, 32'(push_cnt), NumRd);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
    chk({tag, "_done_after_push"}, 32'(done_cyc), 32'(last_push_cyc + 1));
    chk({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    start = 1'b0;
    tile_base_n = '0; tile_base_row = '0; tile_base_col = '0;
    fifo_almost_full = 1'b0;
    mem_rd_ready = 1'b1;
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    repeat (3) tick();
    chk("rst_req", {31'd0, mem_rd_req}, 0);
    chk("rst_push", {31'd0, fifo_push_tmp}, 0);
    chk("rst_data", data_to_fifo_tmp, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst = 1'b0;

    // Origin tile, full-rate memory; a start while busy must be ignored.
    begin_tile(16'd0, 16'd0, 16'd0);
    chk("busy_after_start", {31'd0, busy}, 1);
    wait_acc(5);
    pulse_start();
    finish_tile("t0");
    chk("t0_addr0", 32'(acc_addr[0]), 0);
    chk("t0_addr5", 32'(acc_addr[5]), 5);
    chk("t0_addr6", 32'(acc_addr[6]), 6);
    chk("t0_addr11", 32'(acc_addr[11]), 11);
    chk("t0_addr12", 32'(acc_addr[12]), 24);
    chk("t0_addr23", 32'(acc_addr[23]), 35);
    chk("t0_back_to_back", 32'(last_acc_cyc - first_acc_cyc), 23);

    // Offset tile with a randomly stalling ready.
    rdy_rand = 1;
    begin_tile(16'd2, 16'd2, 16'd2);
    finish_tile("t1");
    chk("t1_first_addr", 32'(acc_addr[0]), 62);
    chk("t1_last_addr", 32'(acc_addr[23]), 97);
    rdy_rand = 0;

    // Memory withholds returns: the outstanding limit must cap requests at four.
    mem_en = 0;
    begin_tile(16'd0, 16'd1, 16'd0);
    repeat (20) tick();
    chk("cap_accepts", 32'(b_acc), 4);
    chk("cap_req_low", {31'd0, mem_rd_req}, 0);
    mem_en = 1;
    finish_tile("t2");

    // Back-pressure held for ten cycles mid-tile.
    begin_tile(16'd1, 16'd0, 16'd1);
    wait_acc(8);
    fifo_almost_full = 1'b1;
    a0 = b_acc;
    repeat (10) tick();
    chk("af_no_accepts", 32'(b_acc), 32'(a0));
    chk("af_req_low", {31'd0, mem_rd_req}, 0);
    fifo_almost_full = 1'b0;
    finish_tile("t3");

    // Reset mid-tile abandons it; the next tile must run cleanly.
    begin_tile(16'd0, 16'd0, 16'd0);
    wait_acc(10);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_rd_req}, 0);
    chk("mid_rst_push", {31'd0, fifo_push_tmp}, 0);
    chk("mid_rst_data", data_to_fifo_tmp, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    repeat (2) tick();
    rst = 1'b0;
    begin_tile(16'd1, 16'd0, 16'd3);
    finish_tile("t4");
    chk("t4_first_addr", 32'(acc_addr[0]), 27);
    chk("t4_last_addr", 32'(acc_addr[23]), 62);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
